// File: rtl/if_bpu.sv
//------------------------------------------------------------------------------
// if_bpu -- fetch-stage branch predictor
//
// Purpose:
//   Combinational next-PC prediction for the instruction being fetched.
//   Conditional branches use a table of 2-bit saturating counters (BHT).
//   JAL is always predicted taken to pc+J_imm. JALR can optionally use a
//   small direct-mapped target buffer (BTB). Both tables are trained by
//   resolved control-transfer updates coming back from EX.
//
// Optional feature:
//   BPU_BTB_EN  -- when defined, the JALR target buffer is built. When it is
//                  undefined there is no BTB storage, JALR always predicts
//                  not-taken (pc+4) and upd_is_jalr_i is ignored.
//
// Parameters:
//   PC_W       PC / target width
//   BHT_DEPTH  number of 2-bit counters (power of two, >= 4)
//   BTB_DEPTH  number of BTB entries (power of two, >= 2)
//
// Ports:
//   clk             rising-edge clock
//   rst             asynchronous active-high reset
//   pc_i            PC of the fetched instruction
//   inst_i          fetched instruction word
//   predict_is_yes  predicted taken
//   pre_pc_o        predicted next PC
//   upd_valid_i     resolved update valid this cycle
//   upd_is_bxx_i    update is a conditional branch (trains the BHT)
//   upd_is_jalr_i   update is a JALR (writes the BTB)
//   upd_pc_i        PC of the resolved instruction
//   upd_taken_i     resolved direction
//   upd_target_i    resolved target
//------------------------------------------------------------------------------
module if_bpu #(
   parameter int PC_W      = 64,
   parameter int BHT_DEPTH = 64,
   parameter int BTB_DEPTH = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [PC_W-1:0] pc_i,
   input  logic [31:0]     inst_i,
   output logic            predict_is_yes,
   output logic [PC_W-1:0] pre_pc_o,
   input  logic            upd_valid_i,
   input  logic            upd_is_bxx_i,
   input  logic            upd_is_jalr_i,
   input  logic [PC_W-1:0] upd_pc_i,
   input  logic            upd_taken_i,
   input  logic [PC_W-1:0] upd_target_i
);

   localparam int BHT_IW = $clog2(BHT_DEPTH);
   localparam int BTB_IW = $clog2(BTB_DEPTH);
   localparam int TAG_W  = PC_W - BTB_IW - 2;

   localparam logic [6:0] OPC_BXX  = 7'b1100011;
   localparam logic [6:0] OPC_JAL  = 7'b1101111;
   localparam logic [6:0] OPC_JALR = 7'b1100111;

   localparam logic [PC_W-1:0] PC_STEP = {{(PC_W-3){1'b0}}, 3'b100};
   localparam logic [1:0]      CNT_RST = 2'b01;

   // Saturating counter helpers
   function automatic logic [1:0] cnt_inc(input logic [1:0] c);
      if (c == 2'b11) begin
         cnt_inc = 2'b11;
      end else begin
         cnt_inc = c + 2'b01;
      end
   endfunction

   function automatic logic [1:0] cnt_dec(input logic [1:0] c);
      if (c == 2'b00) begin
         cnt_dec = 2'b00;
      end else begin
         cnt_dec = c - 2'b01;
      end
   endfunction

   //---------------------------------------------------------------------------
   // Decode
   //---------------------------------------------------------------------------
   logic [6:0]      opcode_s;
   logic [2:0]      funct3_s;
   logic            is_bxx_s;
   logic            is_jal_s;
   logic            is_jalr_s;
   logic [12:0]     b_raw_s;
   logic [20:0]     j_raw_s;
   logic [PC_W-1:0] b_imm_s;
   logic [PC_W-1:0] j_imm_s;

   assign opcode_s  = inst_i[6:0];
   assign funct3_s  = inst_i[14:12];
   assign is_bxx_s  = (opcode_s == OPC_BXX);
   assign is_jal_s  = (opcode_s == OPC_JAL);
   assign is_jalr_s = (opcode_s == OPC_JALR) && (funct3_s == 3'b000);

   // B/J immediates are scrambled in the encoding; bit 0 is always zero.
   assign b_raw_s = {inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
   assign j_raw_s = {inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
   assign b_imm_s = {{(PC_W-13){b_raw_s[12]}}, b_raw_s};
   assign j_imm_s = {{(PC_W-21){j_raw_s[20]}}, j_raw_s};

   //---------------------------------------------------------------------------
   // Branch history table
   //---------------------------------------------------------------------------
   logic [1:0]        bht_q [BHT_DEPTH];
   logic [1:0]        bht_d [BHT_DEPTH];
   logic [BHT_IW-1:0] bht_rd_idx_s;
   logic [BHT_IW-1:0] bht_wr_idx_s;

   assign bht_rd_idx_s = pc_i[BHT_IW+1:2];
   assign bht_wr_idx_s = upd_pc_i[BHT_IW+1:2];

   // Next-state of the counter table: only the update index can move
   always_comb begin
      bht_d = bht_q;
      if (upd_valid_i && upd_is_bxx_i) begin
         if (upd_taken_i) begin
            bht_d[bht_wr_idx_s] = cnt_inc(bht_q[bht_wr_idx_s]);
         end else begin
            bht_d[bht_wr_idx_s] = cnt_dec(bht_q[bht_wr_idx_s]);
         end
      end else begin
         bht_d = bht_q;
      end
   end

   // Counter table state; reset forces every entry to weakly not-taken
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BHT_DEPTH; i++) begin
            bht_q[i] <= CNT_RST;
         end
      end else begin
         bht_q <= bht_d;
      end
   end

   //---------------------------------------------------------------------------
   // JALR target buffer
   //---------------------------------------------------------------------------
   logic            btb_hit_s;
   logic [PC_W-1:0] btb_target_s;
   logic            unused_s;

`ifdef BPU_BTB_EN
   logic              btb_valid_q [BTB_DEPTH];
   logic              btb_valid_d [BTB_DEPTH];
   logic [TAG_W-1:0]  btb_tag_q   [BTB_DEPTH];
   logic [TAG_W-1:0]  btb_tag_d   [BTB_DEPTH];
   logic [PC_W-1:0]   btb_tgt_q   [BTB_DEPTH];
   logic [PC_W-1:0]   btb_tgt_d   [BTB_DEPTH];
   logic [BTB_IW-1:0] btb_rd_idx_s;
   logic [BTB_IW-1:0] btb_wr_idx_s;
   logic              btb_we_s;

   assign btb_rd_idx_s = pc_i[BTB_IW+1:2];
   assign btb_wr_idx_s = upd_pc_i[BTB_IW+1:2];
   // Tag/target flops have no reset, so gate writes explicitly during reset.
   assign btb_we_s     = upd_valid_i && upd_is_jalr_i && !rst;

   assign btb_hit_s    = btb_valid_q[btb_rd_idx_s] &&
                         (btb_tag_q[btb_rd_idx_s] == pc_i[PC_W-1:BTB_IW+2]);
   assign btb_target_s = btb_tgt_q[btb_rd_idx_s];
   assign unused_s     = ^upd_pc_i[1:0];

   // Next-state of the BTB: a write replaces the whole entry at its index
   always_comb begin
      btb_valid_d = btb_valid_q;
      btb_tag_d   = btb_tag_q;
      btb_tgt_d   = btb_tgt_q;
      if (btb_we_s) begin
         btb_valid_d[btb_wr_idx_s] = 1'b1;
         btb_tag_d[btb_wr_idx_s]   = upd_pc_i[PC_W-1:BTB_IW+2];
         btb_tgt_d[btb_wr_idx_s]   = upd_target_i;
      end else begin
         btb_valid_d = btb_valid_q;
      end
   end

   // BTB valid bits; cleared asynchronously so a reset forces misses at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BTB_DEPTH; i++) begin
            btb_valid_q[i] <= 1'b0;
         end
      end else begin
         btb_valid_q <= btb_valid_d;
      end
   end

   // BTB tag/target payload; meaningless while valid is clear, so not reset
   always_ff @(posedge clk) begin
      btb_tag_q <= btb_tag_d;
      btb_tgt_q <= btb_tgt_d;
   end
`else
   assign btb_hit_s    = 1'b0;
   assign btb_target_s = {PC_W{1'b0}};
   assign unused_s     = ^{upd_pc_i[1:0], upd_pc_i[PC_W-1:BHT_IW+2],
                           upd_is_jalr_i, upd_target_i, TAG_W[0]};
`endif

   //---------------------------------------------------------------------------
   // Prediction (purely combinational from current table contents)
   //---------------------------------------------------------------------------
   logic            pred_s;
   logic [PC_W-1:0] next_pc_s;
   logic [PC_W-1:0] seq_pc_s;

   assign seq_pc_s = pc_i + PC_STEP;

   // Select prediction by instruction class; default is fall-through
   always_comb begin
      pred_s    = 1'b0;
      next_pc_s = seq_pc_s;
      if (is_bxx_s) begin
         pred_s = bht_q[bht_rd_idx_s][1];
         if (pred_s) begin
            next_pc_s = pc_i + b_imm_s;
         end else begin
            next_pc_s = seq_pc_s;
         end
      end else if (is_jal_s) begin
         pred_s    = 1'b1;
         next_pc_s = pc_i + j_imm_s;
      end else if (is_jalr_s && btb_hit_s) begin
         pred_s    = 1'b1;
         next_pc_s = btb_target_s;
      end else begin
         pred_s    = 1'b0;
         next_pc_s = seq_pc_s;
      end
   end

   assign predict_is_yes = pred_s;
   assign pre_pc_o       = next_pc_s;

endmodule

// File: tb/tb_if_bpu.sv
//------------------------------------------------------------------------------
// tb_if_bpu -- self-checking bench for if_bpu
// Directed scenarios followed by randomized lookups/updates, all compared
// against a table-level reference model of the predictor.
//------------------------------------------------------------------------------
module tb_if_bpu;

   localparam int PC_W      = 64;
   localparam int BHT_DEPTH = 64;
   localparam int BTB_DEPTH = 16;

   localparam int K_BXX   = 0;
   localparam int K_JAL   = 1;
   localparam int K_JALR  = 2;
   localparam int K_OTHER = 3;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [63:0]     pc_i = 64'd0;
   logic [31:0]     inst_i = 32'h0000_0013;
   logic            predict_is_yes;
   logic [63:0]     pre_pc_o;
   logic            upd_valid_i = 1'b0;
   logic            upd_is_bxx_i = 1'b0;
   logic            upd_is_jalr_i = 1'b0;
   logic [63:0]     upd_pc_i = 64'd0;
   logic            upd_taken_i = 1'b0;
   logic [63:0]     upd_target_i = 64'd0;

   int tests_run    = 0;
   int tests_failed = 0;

   logic        last_pred;
   logic [63:0] last_npc;

   // reference model state
   int          bht_m   [BHT_DEPTH];
   bit          btb_v_m [BTB_DEPTH];
   logic [63:0] btb_t_m [BTB_DEPTH];
   logic [63:0] btb_g_m [BTB_DEPTH];

   if_bpu #(.PC_W(PC_W), .BHT_DEPTH(BHT_DEPTH), .BTB_DEPTH(BTB_DEPTH)) dut (
      .clk(clk), .rst(rst), .pc_i(pc_i), .inst_i(inst_i),
      .predict_is_yes(predict_is_yes), .pre_pc_o(pre_pc_o),
      .upd_valid_i(upd_valid_i), .upd_is_bxx_i(upd_is_bxx_i),
      .upd_is_jalr_i(upd_is_jalr_i), .upd_pc_i(upd_pc_i),
      .upd_taken_i(upd_taken_i), .upd_target_i(upd_target_i)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] enc_b(input int imm);
      logic [31:0] v;
      logic [12:0] b;
      v = imm;
      b = v[12:0];
      return {b[12], b[10:5], 5'd3, 5'd1, 3'b000, b[4:1], b[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] enc_j(input int imm);
      logic [31:0] v;
      logic [20:0] j;
      v = imm;
      j = v[20:0];
      return {j[20], j[10:1], j[11], j[19:12], 5'd1, 7'b1101111};
   endfunction

   function automatic logic [31:0] enc_jalr(input int imm, input logic [2:0] f3);
      logic [31:0] v;
      v = imm;
      return {v[11:0], 5'd1, f3, 5'd1, 7'b1100111};
   endfunction

   function automatic logic [63:0] sext(input int imm);
      longint l;
      l = imm;
      return l;
   endfunction

   function automatic int bht_ix(input logic [63:0] pc);
      return int'((pc >> 2) % BHT_DEPTH);
   endfunction

   function automatic int btb_ix(input logic [63:0] pc);
      return int'((pc >> 2) % BTB_DEPTH);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < BHT_DEPTH; i++) bht_m[i] = 1;
      for (int i = 0; i < BTB_DEPTH; i++) btb_v_m[i] = 1'b0;
   endtask

   task automatic model_lookup(input int kind, input int imm, input logic [63:0] pc,
                               output logic pred, output logic [63:0] npc);
      pred = 1'b0;
      npc  = pc + 64'd4;
      if (kind == K_BXX) begin
         pred = (bht_m[bht_ix(pc)] >= 2);
         if (pred) npc = pc + sext(imm);
      end else if (kind == K_JAL) begin
         pred = 1'b1;
         npc  = pc + sext(imm);
      end else if (kind == K_JALR) begin
`ifdef BPU_BTB_EN
         if (btb_v_m[btb_ix(pc)] && btb_t_m[btb_ix(pc)] == (pc >> 6)) begin
            pred = 1'b1;
            npc  = btb_g_m[btb_ix(pc)];
         end
`endif
      end
   endtask

   task automatic model_update(input logic uv, input logic ub, input logic uj,
                               input logic [63:0] upc, input logic ut, input logic [63:0] utgt);
      if (uv && ub) begin
         if (ut) bht_m[bht_ix(upc)] = (bht_m[bht_ix(upc)] == 3) ? 3 : bht_m[bht_ix(upc)] + 1;
         else    bht_m[bht_ix(upc)] = (bht_m[bht_ix(upc)] == 0) ? 0 : bht_m[bht_ix(upc)] - 1;
      end
`ifdef BPU_BTB_EN
      if (uv && uj) begin
         btb_v_m[btb_ix(upc)] = 1'b1;
         btb_t_m[btb_ix(upc)] = upc >> 6;
         btb_g_m[btb_ix(upc)] = utgt;
      end
`endif
   endtask

   task automatic drive_lookup(input int kind, input int imm, input logic [63:0] pc);
      logic [31:0] r;
      pc_i = pc;
      case (kind)
         K_BXX:   inst_i = enc_b(imm);
         K_JAL:   inst_i = enc_j(imm);
         K_JALR:  inst_i = enc_jalr(imm, 3'b000);
         default: begin
            r = $urandom;
            if (r[0]) inst_i = enc_jalr(imm, 3'b001);
            else      inst_i = {r[31:7], 7'b0110011};
         end
      endcase
   endtask

   // one cycle: drive lookup+update, compare before the edge, advance model
   task automatic step(input int kind, input int imm, input logic [63:0] pc,
                       input logic uv, input logic ub, input logic uj,
                       input logic [63:0] upc, input logic ut, input logic [63:0] utgt);
      logic        ep;
      logic [63:0] enpc;
      drive_lookup(kind, imm, pc);
      upd_valid_i = uv; upd_is_bxx_i = ub; upd_is_jalr_i = uj;
      upd_pc_i = upc; upd_taken_i = ut; upd_target_i = utgt;
      #2;
      model_lookup(kind, imm, pc, ep, enpc);
      last_pred = predict_is_yes;
      last_npc  = pre_pc_o;
      check_val("pred", {63'd0, predict_is_yes}, {63'd0, ep});
      check_val("npc", pre_pc_o, enpc);
      @(posedge clk);
      if (!rst) model_update(uv, ub, uj, upc, ut, utgt);
      #1;
      upd_valid_i = 1'b0;
   endtask

   task automatic lookup(input int kind, input int imm, input logic [63:0] pc);
      step(kind, imm, pc, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
   endtask

   initial begin
      model_reset();
      // reset held: lookups see reset tables, updates must be ignored
      step(K_BXX, 32, 64'h1000, 1'b1, 1'b1, 1'b1, 64'h1000, 1'b1, 64'h5000);
      step(K_BXX, 32, 64'h1000, 1'b1, 1'b1, 1'b0, 64'h1000, 1'b1, 64'h0);
      rst = 1'b0;
      #1;

      // fresh counter: weakly not-taken
      lookup(K_BXX, 32, 64'h1000);
      check_val("rst_bxx_pred", {63'd0, last_pred}, 64'd0);
      check_val("rst_bxx_npc", last_npc, 64'h1004);
      // two taken updates -> taken
      step(K_OTHER, 0, 64'h40, 1'b1, 1'b1, 1'b0, 64'h1000, 1'b1, 64'd0);
      step(K_OTHER, 0, 64'h40, 1'b1, 1'b1, 1'b0, 64'h1000, 1'b1, 64'd0);
      lookup(K_BXX, 32, 64'h1000);
      check_val("train_pred", {63'd0, last_pred}, 64'd1);
      check_val("train_npc", last_npc, 64'h1020);
      // saturate then one not-taken: still taken
      for (int i = 0; i < 3; i++)
         step(K_OTHER, 0, 64'h40, 1'b1, 1'b1, 1'b0, 64'h1000, 1'b1, 64'd0);
      step(K_OTHER, 0, 64'h40, 1'b1, 1'b1, 1'b0, 64'h1000, 1'b0, 64'd0);
      lookup(K_BXX, 32, 64'h1000);
      check_val("sat_pred", {63'd0, last_pred}, 64'd1);
      check_val("sat_npc", last_npc, 64'h1020);
      // jal backward
      lookup(K_JAL, -8, 64'h2000);
      check_val("jal_pred", {63'd0, last_pred}, 64'd1);
      check_val("jal_npc", last_npc, 64'h1FF8);

      // jalr via BTB
      lookup(K_JALR, 0, 64'h3000);
      check_val("jalr_miss_npc", last_npc, 64'h3004);
      step(K_OTHER, 0, 64'h40, 1'b1, 1'b0, 1'b1, 64'h3000, 1'b1, 64'h8000);
      lookup(K_JALR, 0, 64'h3000);
`ifdef BPU_BTB_EN
      check_val("jalr_hit_npc", last_npc, 64'h8000);
`else
      check_val("jalr_nobtb_npc", last_npc, 64'h3004);
`endif
      step(K_OTHER, 0, 64'h40, 1'b1, 1'b0, 1'b1, 64'h3040, 1'b1, 64'h9000);
      lookup(K_JALR, 0, 64'h3000);
      check_val("jalr_alias_npc", last_npc, 64'h3004);

      // same-cycle update and lookup of index 5
      step(K_BXX, 32, 64'h14, 1'b1, 1'b1, 1'b0, 64'h14, 1'b1, 64'd0);
      check_val("bypass_old_pred", {63'd0, last_pred}, 64'd0);
      lookup(K_BXX, 32, 64'h14);
      check_val("bypass_new_npc", last_npc, 64'h34);

      // mid-run asynchronous reset
      step(K_OTHER, 0, 64'h40, 1'b1, 1'b0, 1'b1, 64'h3000, 1'b1, 64'h8000);
      drive_lookup(K_BXX, 32, 64'h1000);
      #1;
      check_val("pre_rst_pred", {63'd0, predict_is_yes}, 64'd1);
      rst = 1'b1;
      #1;
      model_reset();
      check_val("async_rst_pred", {63'd0, predict_is_yes}, 64'd0);
      check_val("async_rst_npc", pre_pc_o, 64'h1004);
      drive_lookup(K_JALR, 0, 64'h3000);
      #1;
      check_val("async_rst_jalr", pre_pc_o, 64'h3004);
      drive_lookup(K_JAL, -8, 64'h2000);
      #1;
      check_val("async_rst_jal", pre_pc_o, 64'h1FF8);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // wrap-around
      lookup(K_OTHER, 0, 64'hFFFF_FFFF_FFFF_FFFC);
      check_val("wrap_npc", last_npc, 64'd0);

      // randomized traffic over a small PC pool to force aliasing
      for (int n = 0; n < 400; n++) begin
         int          kind;
         int          imm;
         logic [63:0] pc;
         logic [63:0] upc;
         kind = $urandom_range(0, 3);
         if (kind == K_JAL) imm = ($urandom_range(0, 1048575) - 524288) * 2;
         else               imm = ($urandom_range(0, 4095) - 2048) * 2;
         pc  = 64'h3000 + 64'({$urandom_range(0, 127), 2'b00});
         upc = 64'h3000 + 64'({$urandom_range(0, 127), 2'b00});
         if ($urandom_range(0, 15) == 0) pc = {$urandom, $urandom} & ~64'd3;
         step(kind, imm, pc, ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
              upc, 1'($urandom), {$urandom, $urandom});
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/if_bpu.md
IF_BPU -- requirements
Module: if_bpu

Interface
REQ-001 SHALL provide parameter PC_W, default 64, PC and target width.
REQ-002 SHALL provide parameter BHT_DEPTH, default 64, number of 2-bit counters, power of two >= 4.
REQ-003 SHALL provide parameter BTB_DEPTH, default 16, number of direct-mapped JALR target entries, power of two >= 2.
REQ-004 SHALL provide port clk, input, 1, the single clock; rising-edge only.
REQ-005 SHALL provide port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL provide port pc_i, input, PC_W, PC of the fetched instruction.
REQ-007 SHALL provide port inst_i, input, 32, the fetched instruction.
REQ-008 SHALL provide port predict_is_yes, output, 1, predicted taken.
REQ-009 SHALL provide port pre_pc_o, output, PC_W, predicted next PC.
REQ-010 SHALL provide port upd_valid_i, input, 1, resolved control-transfer update from EX is valid this cycle.
REQ-011 SHALL provide port upd_is_bxx_i, input, 1, the update is a conditional branch.
REQ-012 SHALL provide port upd_is_jalr_i, input, 1, the update is a JALR.
REQ-013 SHALL provide port upd_pc_i, input, PC_W, PC of the resolved instruction.
REQ-014 SHALL provide port upd_taken_i, input, 1, resolved direction.
REQ-015 SHALL provide port upd_target_i, input, PC_W, resolved target.

Function
REQ-016 Lookup SHALL be combinational, zero cycles from pc_i/inst_i to outputs.
REQ-017 Decode: bxx = opcode 1100011; jal = 1101111; jalr = 1100111 with funct3 000. B and J immediates SHALL be sign-extended to PC_W with bit 0 = 0.
REQ-018 BHT index SHALL be pc[log2(BHT_DEPTH)+1:2]. BTB index SHALL be pc[log2(BTB_DEPTH)+1:2]. BTB tag SHALL be pc[PC_W-1:log2(BTB_DEPTH)+2].
REQ-019 For bxx, predict_is_yes SHALL equal the indexed counter bit 1. pre_pc_o SHALL be pc_i+B_imm when taken, else pc_i+4.
REQ-020 For jal, predict_is_yes SHALL be 1 and pre_pc_o SHALL be pc_i+J_imm.
REQ-021 For jalr on a BTB hit (valid and tag match), predict_is_yes SHALL be 1 and pre_pc_o SHALL be the stored target. On a miss, predict_is_yes SHALL be 0 and pre_pc_o SHALL be pc_i+4.
REQ-022 For any other instruction, predict_is_yes SHALL be 0 and pre_pc_o SHALL be pc_i+4.
REQ-023 All additions SHALL be modulo 2^PC_W and wrap without error.
REQ-024 Counter update: on a rising edge with upd_valid_i && upd_is_bxx_i, the counter at the upd_pc_i index SHALL increment when taken and decrement when not taken.
REQ-025 The counter SHALL saturate at 3 (taken) and at 0 (not taken).
REQ-026 BTB update: on a rising edge with upd_valid_i && upd_is_jalr_i, the entry at the upd_pc_i index SHALL be written. The write sets valid=1, tag from upd_pc_i and target=upd_target_i, replacing any previous entry.
REQ-027 When upd_valid_i is 0, no state SHALL change. upd_is_bxx_i and upd_is_jalr_i both high SHALL update both structures.
REQ-028 A lookup and an update to the same index in the same cycle SHALL return the pre-update value; the new value SHALL be visible from the next cycle.
REQ-029 Updates to different indices SHALL never disturb other entries.

Reset
REQ-030 While rst=1, all counters SHALL be 2'b01 (weakly not-taken) and all BTB valid bits SHALL be 0, asynchronously. BTB tag and target contents need not be reset.
REQ-031 Reset asserted mid-operation SHALL take effect immediately. The outputs SHALL then be: bxx predict_is_yes=0 with pre_pc_o=pc_i+4; jalr treated as a miss; jal unaffected.
REQ-032 While rst=1, updates SHALL be ignored.

Configuration
REQ-033 Macro BPU_BTB_EN: when defined, the BTB and REQ-021/026 SHALL be implemented.
REQ-034 When BPU_BTB_EN is undefined, no BTB storage SHALL exist. JALR SHALL always predict predict_is_yes=0 with pre_pc_o=pc_i+4, and upd_is_jalr_i SHALL be ignored.

Verification
REQ-035 Reset, then bxx at pc=0x1000 with B_imm=+0x20 -> predict_is_yes=0, pre_pc_o=0x1004.
REQ-036 Two taken updates at upd_pc=0x1000, then the same bxx lookup -> predict_is_yes=1, pre_pc_o=0x1020. After three more taken updates and one not-taken update, the prediction remains taken (counter 3->2).
REQ-037 jal at pc=0x2000 with J_imm=-8 -> predict_is_yes=1, pre_pc_o=0x1FF8, in any BHT state.
REQ-038 With BPU_BTB_EN: jalr at 0x3000 misses (pre_pc_o=0x3004). After update with target 0x8000 it hits (0x8000). An update at 0x3040 (same index, different tag) makes a 0x3000 lookup miss again.
REQ-039 Update and lookup of index 5 in the same cycle -> old prediction in that cycle, new prediction next cycle.
REQ-040 Assert rst mid-run after training -> bxx prediction drops to not-taken and the BTB misses without waiting for a clock edge. pc=0xFFFF_FFFF_FFFF_FFFC with a non-branch -> pre_pc_o=0.
